// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, ASCII constants and the
// hex character decoder used by the receive side and mirrored by the TX side.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UF = 8'h46;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LF = 8'h66;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } hex_nibble_t;

  // Digits carry their value in the low nibble; letters a-f / A-F have low
  // nibbles 1..6, so adding 9 yields 10..15 for either case.
  function automatic hex_nibble_t hex_decode(input logic [7:0] ch);
    hex_nibble_t res;
    res = '0;
    if (ch >= ASCII_0 && ch <= ASCII_9) begin
      res.valid  = 1'b1;
      res.nibble = ch[3:0];
    end else if ((ch >= ASCII_LA && ch <= ASCII_LF) ||
                 (ch >= ASCII_UA && ch <= ASCII_UF)) begin
      res.valid  = 1'b1;
      res.nibble = ch[3:0] + 4'd9;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop input synchroniser followed by a start / data /
// stop bit FSM. Produces a one-cycle byte_done strobe with the received byte
// and a sticky frame error when a stop bit is sampled low.
module uart_rx #(
  parameter int CLK_FREQ = 1000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_done,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  import uart_pkg::*;

  localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD;
  localparam int CYC_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(CYCLES_PER_BIT / 2);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES_PER_BIT - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             rxs;
  uart_state_t      state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;

  assign rxs       = sync2_q;
  assign byte_data = shift_q;
  assign frame_err = frame_err_q;

  // Bring the asynchronous line into the clock domain; resets to the idle level
  // so a reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Receiver state, counters, shift register and sticky frame error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: confirm the start bit at mid-bit, then sample each data
  // bit and the stop bit one full bit period apart, LSB first.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = frame_err_q;
    byte_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cyc_d   = '0;
        end
      end
      START: begin
        if (cyc_q == CYC_HALF) begin
          cyc_d = '0;
          if (!rxs) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      DATA: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      STOP: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d   = '0;
          state_d = IDLE;
          if (rxs) begin
            byte_done = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_hex_chunk_rx.sv
// ASCII hex receiver that packs nibbles into WIDTH-bit chunks for the keccak
// message input. The first character received lands in chunk[3:0]. A full
// chunk is held on a valid/ready port; characters arriving while it is held
// and not being accepted are dropped and flagged.
module uart_hex_chunk_rx #(
  parameter int CLK_FREQ = 1000000,
  parameter int BAUD     = 9600,
  parameter int WIDTH    = 576
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [WIDTH-1:0] chunk,
  output logic             chunk_valid,
  input  logic             chunk_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             bad_char
);
  import uart_pkg::*;

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  logic             byte_done;
  logic [7:0]       byte_data;
  hex_nibble_t      dec;
  logic             transfer;
  logic [WIDTH-1:0] chunk_q, chunk_d;
  logic             chunk_valid_q, chunk_valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             overrun_q, overrun_d;
  logic             bad_char_q, bad_char_d;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .byte_done(byte_done),
    .byte_data(byte_data),
    .frame_err(frame_err)
  );

  assign dec         = hex_decode(byte_data);
  assign transfer    = chunk_valid_q & chunk_ready;
  assign chunk       = chunk_q;
  assign chunk_valid = chunk_valid_q;
  assign overrun     = overrun_q;
  assign bad_char    = bad_char_q;

  // Packer registers: chunk data, nibble index, hold flag and sticky errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chunk_q       <= '0;
      chunk_valid_q <= 1'b0;
      idx_q         <= '0;
      overrun_q     <= 1'b0;
      bad_char_q    <= 1'b0;
    end else begin
      chunk_q       <= chunk_d;
      chunk_valid_q <= chunk_valid_d;
      idx_q         <= idx_d;
      overrun_q     <= overrun_d;
      bad_char_q    <= bad_char_d;
    end
  end

  // A transfer releases the held chunk in the same cycle a new nibble may
  // arrive, so that nibble starts the next chunk instead of being dropped.
  always_comb begin
    chunk_d       = chunk_q;
    chunk_valid_d = chunk_valid_q;
    idx_d         = idx_q;
    overrun_d     = overrun_q;
    bad_char_d    = bad_char_q;
    if (transfer) begin
      chunk_valid_d = 1'b0;
    end
    if (byte_done) begin
      if (!dec.valid) begin
        bad_char_d = 1'b1;
      end else if (chunk_valid_q && !chunk_ready) begin
        overrun_d = 1'b1;
      end else begin
        chunk_d[{idx_q, 2'b00} +: 4] = dec.nibble;
        if (idx_q == IDX_LAST) begin
          chunk_valid_d = 1'b1;
          idx_d         = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_chunk_rx.sv
// Bench for uart_hex_chunk_rx: a 16-bit instance at 9600 baud for the feature
// scenarios and a 576-bit instance on a faster line for full-width streaming.
module tb_uart_hex_chunk_rx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD_S   = 9600;
  localparam int CPB_S    = CLK_FREQ / BAUD_S;
  localparam int BAUD_B   = 166666;
  localparam int CPB_B    = CLK_FREQ / BAUD_B;
  localparam int W_S      = 16;
  localparam int W_B      = 576;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           rx_s = 1'b1;
  logic           rx_b = 1'b1;
  logic           ready_s = 1'b0;
  logic           ready_b = 1'b1;
  logic [W_S-1:0] chunk_s;
  logic [W_B-1:0] chunk_b;
  logic           valid_s, valid_b;
  logic           fe_s, fe_b, ovr_s, ovr_b, bad_s, bad_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_hex_chunk_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD_S), .WIDTH(W_S)) dut_s (
    .clk(clk), .reset(reset), .rx(rx_s), .chunk(chunk_s), .chunk_valid(valid_s),
    .chunk_ready(ready_s), .frame_err(fe_s), .overrun(ovr_s), .bad_char(bad_s));

  uart_hex_chunk_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD_B), .WIDTH(W_B)) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .chunk(chunk_b), .chunk_valid(valid_b),
    .chunk_ready(ready_b), .frame_err(fe_b), .overrun(ovr_b), .bad_char(bad_b));

  // Transfers observed on each port, captured away from the active edge.
  logic [W_S-1:0] got_s[$];
  logic [W_B-1:0] got_b[$];
  int vcyc_s = 0;
  int vcyc_b = 0;

  always @(negedge clk) begin
    if (valid_s === 1'b1) vcyc_s++;
    if (valid_b === 1'b1) vcyc_b++;
    if (valid_s === 1'b1 && ready_s === 1'b1) got_s.push_back(chunk_s);
    if (valid_b === 1'b1 && ready_b === 1'b1) got_b.push_back(chunk_b);
  end

  // Character-level reference model of the 16-bit packer.
  int             m_nib[4];
  int             m_idx;
  bit             m_valid, m_bad, m_ovr, m_fe;
  logic [W_S-1:0] exp_s[$];

  function automatic int ref_decode(input logic [7:0] c);
    string lo = "0123456789abcdef";
    string up = "0123456789ABCDEF";
    for (int i = 0; i < 16; i++)
      if (c == lo[i] || c == up[i]) return i;
    return -1;
  endfunction

  function automatic logic [W_S-1:0] m_chunk();
    logic [W_S-1:0] v = '0;
    for (int i = 0; i < 4; i++) v = v + (W_S'(m_nib[i]) << (4 * i));
    return v;
  endfunction

  task automatic m_reset();
    m_nib = '{default: 0};
    m_idx = 0; m_valid = 0; m_bad = 0; m_ovr = 0; m_fe = 0;
  endtask

  task automatic m_accept();
    if (m_valid) begin
      exp_s.push_back(m_chunk());
      m_valid = 0;
    end
  endtask

  task automatic m_char(input logic [7:0] c, input bit r);
    int n = ref_decode(c);
    if (n < 0) begin
      m_bad = 1;
      return;
    end
    if (m_valid) begin
      if (r) m_accept();
      else begin
        m_ovr = 1;
        return;
      end
    end
    m_nib[m_idx] = n;
    m_idx++;
    if (m_idx == 4) begin
      m_idx = 0;
      m_valid = 1;
      if (r) m_accept();
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_rx(input bit big, input logic v);
    if (big) rx_b = v;
    else rx_s = v;
  endtask

  // One 8N1 frame; a low stop bit covers its centre and then releases early.
  task automatic send_frame(input logic [7:0] b, input bit stop_low, input bit big);
    int cpb = big ? CPB_B : CPB_S;
    drive_rx(big, 1'b0);
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      drive_rx(big, b[i]);
      tick(cpb);
    end
    if (stop_low) begin
      drive_rx(big, 1'b0);
      tick(cpb * 3 / 4);
      drive_rx(big, 1'b1);
      tick(cpb - cpb * 3 / 4);
    end else begin
      drive_rx(big, 1'b1);
      tick(cpb);
    end
    tick(4);
  endtask

  task automatic send_s(input logic [7:0] c, input bit stop_low);
    send_frame(c, stop_low, 1'b0);
    if (stop_low) m_fe = 1;
    else m_char(c, ready_s);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_s(s[i], 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    m_reset();
    checks++;
    if (chunk_s !== '0 || valid_s !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_chunk: got chunk=%h valid=%b, expected 0000/0", chunk_s, valid_s);
    end
    checks++;
    if ({fe_s, ovr_s, bad_s, fe_b, ovr_b, bad_b, valid_b} !== 7'b0 || chunk_b !== '0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got fe/ovr/bad/big=%b, expected all 0",
               {fe_s, ovr_s, bad_s, fe_b, ovr_b, bad_b, valid_b});
    end
    reset = 1'b0;
    tick(5);
  endtask

  task automatic test_basic();
    int v0;
    got_s.delete(); exp_s.delete();
    ready_s = 1'b1;
    v0 = vcyc_s;
    send_str("1a2B");
    checks++;
    if (got_s.size() !== 1 || got_s[0] !== 16'hB2A1 || exp_s[0] !== 16'hB2A1) begin
      errors++;
      $display("[TB] FAIL basic_chunk: got %0d transfers first=%h, expected 1 of b2a1", got_s.size(), got_s[0]);
    end
    checks++;
    if (vcyc_s - v0 !== 1) begin
      errors++;
      $display("[TB] FAIL basic_pulse: got valid high %0d cycles, expected 1", vcyc_s - v0);
    end
    checks++;
    if ({fe_s, ovr_s, bad_s, valid_s} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL basic_flags: got fe/ovr/bad/valid=%b, expected 0000", {fe_s, ovr_s, bad_s, valid_s});
    end
  endtask

  task automatic test_overrun();
    got_s.delete(); exp_s.delete();
    ready_s = 1'b0;
    send_str("0123");
    send_str("4");
    checks++;
    if (valid_s !== 1'b1 || chunk_s !== m_chunk() || chunk_s !== 16'h3210) begin
      errors++;
      $display("[TB] FAIL overrun_hold: got valid=%b chunk=%h, expected 1 %h", valid_s, chunk_s, m_chunk());
    end
    checks++;
    if (ovr_s !== m_ovr || ovr_s !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_flag: got %b, expected %b", ovr_s, m_ovr);
    end
    ready_s = 1'b1;
    m_accept();
    tick(1);
    ready_s = 1'b0;
    send_str("5678");
    checks++;
    if (got_s.size() !== 1 || got_s[0] !== exp_s[0]) begin
      errors++;
      $display("[TB] FAIL overrun_xfer: got %0d transfers first=%h, expected 1 of %h", got_s.size(), got_s[0], exp_s[0]);
    end
    checks++;
    if (valid_s !== m_valid || chunk_s !== m_chunk()) begin
      errors++;
      $display("[TB] FAIL overrun_next: got valid=%b chunk=%h, expected %b %h", valid_s, chunk_s, m_valid, m_chunk());
    end
  endtask

  task automatic test_bad_char();
    got_s.delete(); exp_s.delete();
    ready_s = 1'b1;
    m_accept();
    send_str("9z8f7e");
    checks++;
    if (got_s.size() !== 2 || got_s[0] !== exp_s[0] || got_s[1] !== exp_s[1] || exp_s[1] !== 16'h7F89) begin
      errors++;
      $display("[TB] FAIL badchar_xfer: got %0d transfers last=%h, expected 2 ending 7f89", got_s.size(), got_s[got_s.size()-1]);
    end
    checks++;
    if (bad_s !== m_bad || chunk_s !== m_chunk() || valid_s !== m_valid) begin
      errors++;
      $display("[TB] FAIL badchar_state: got bad=%b chunk=%h valid=%b, expected %b %h %b",
               bad_s, chunk_s, valid_s, m_bad, m_chunk(), m_valid);
    end
  endtask

  task automatic test_glitch_frame();
    got_s.delete(); exp_s.delete();
    rx_s = 1'b0;
    tick(30);
    rx_s = 1'b1;
    tick(CPB_S * 2);
    checks++;
    if ({fe_s, bad_s, ovr_s} !== {m_fe, m_bad, m_ovr} || chunk_s !== m_chunk() || got_s.size() !== 0) begin
      errors++;
      $display("[TB] FAIL glitch: got fe/bad/ovr=%b chunk=%h xfers=%0d, expected %b %h 0",
               {fe_s, bad_s, ovr_s}, chunk_s, got_s.size(), {m_fe, m_bad, m_ovr}, m_chunk());
    end
    send_s("A", 1'b1);
    checks++;
    if (fe_s !== 1'b1 || chunk_s !== m_chunk()) begin
      errors++;
      $display("[TB] FAIL frame_err: got fe=%b chunk=%h, expected 1 %h", fe_s, chunk_s, m_chunk());
    end
    send_str("1");
    checks++;
    if (chunk_s !== m_chunk() || valid_s !== m_valid) begin
      errors++;
      $display("[TB] FAIL frame_idx: got chunk=%h valid=%b, expected %h %b", chunk_s, valid_s, m_chunk(), m_valid);
    end
  endtask

  task automatic test_reset_mid();
    send_str("12");
    rx_s = 1'b0;
    tick(CPB_S * 3 + CPB_S / 2);
    reset = 1'b1;
    rx_s = 1'b1;
    tick(3);
    checks++;
    if ({chunk_s, valid_s, fe_s, ovr_s, bad_s} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got chunk=%h valid/fe/ovr/bad=%b, expected all 0",
               chunk_s, {valid_s, fe_s, ovr_s, bad_s});
    end
    reset = 1'b0;
    m_reset();
    got_s.delete(); exp_s.delete();
    ready_s = 1'b0;
    tick(5);
    send_str("abcd");
    checks++;
    if (chunk_s !== 16'hDCBA || chunk_s !== m_chunk() || valid_s !== 1'b1 || got_s.size() !== 0) begin
      errors++;
      $display("[TB] FAIL reset_resume: got chunk=%h valid=%b xfers=%0d, expected dcba 1 0",
               chunk_s, valid_s, got_s.size());
    end
  endtask

  task automatic test_random();
    string hs = "0123456789abcdef";
    logic [7:0] c;
    got_s.delete(); exp_s.delete();
    ready_s = 1'b1;
    m_accept();
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(4) == 0) c = 8'($urandom_range(255));
      else begin
        c = hs[$urandom_range(15)];
        if (c >= 8'h61 && $urandom_range(1) == 1) c = c - 8'h20;
      end
      send_s(c, 1'b0);
    end
    checks++;
    if (got_s.size() !== exp_s.size()) begin
      errors++;
      $display("[TB] FAIL random_count: got %0d transfers, expected %0d", got_s.size(), exp_s.size());
    end
    for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
      checks++;
      if (got_s[i] !== exp_s[i]) begin
        errors++;
        $display("[TB] FAIL random_chunk%0d: got %h, expected %h", i, got_s[i], exp_s[i]);
      end
    end
    checks++;
    if (chunk_s !== m_chunk() || {valid_s, bad_s, ovr_s, fe_s} !== {m_valid, m_bad, m_ovr, m_fe}) begin
      errors++;
      $display("[TB] FAIL random_state: got chunk=%h valid/bad/ovr/fe=%b, expected %h %b",
               chunk_s, {valid_s, bad_s, ovr_s, fe_s}, m_chunk(), {m_valid, m_bad, m_ovr, m_fe});
    end
  endtask

  task automatic test_wide();
    string hs = "0123456789abcdef";
    logic [7:0]     chars[288];
    logic [W_B-1:0] expw[2];
    int v0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    m_reset();
    tick(5);
    got_b.delete();
    ready_b = 1'b1;
    for (int i = 0; i < 288; i++) begin
      chars[i] = hs[$urandom_range(15)];
      if (chars[i] >= 8'h61 && $urandom_range(1) == 1) chars[i] = chars[i] - 8'h20;
    end
    for (int k = 0; k < 2; k++) begin
      expw[k] = '0;
      for (int i = 0; i < 144; i++)
        expw[k] = expw[k] | (W_B'(ref_decode(chars[144 * k + i])) << (4 * i));
    end
    v0 = vcyc_b;
    for (int i = 0; i < 144; i++) send_frame(chars[i], 1'b0, 1'b1);
    checks++;
    if (got_b.size() !== 1 || got_b[0] !== expw[0]) begin
      errors++;
      $display("[TB] FAIL wide_first: got %0d transfers first=%h, expected 1 of %h", got_b.size(), got_b[0], expw[0]);
    end
    for (int i = 144; i < 288; i++) send_frame(chars[i], 1'b0, 1'b1);
    checks++;
    if (got_b.size() !== 2 || got_b[1] !== expw[1]) begin
      errors++;
      $display("[TB] FAIL wide_second: got %0d transfers last=%h, expected 2 ending %h",
               got_b.size(), got_b[got_b.size()-1], expw[1]);
    end
    checks++;
    if (vcyc_b - v0 !== 2 || {fe_b, ovr_b, bad_b, valid_b} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL wide_pulses: got %0d valid cycles flags=%b, expected 2 0000",
               vcyc_b - v0, {fe_b, ovr_b, bad_b, valid_b});
    end
  endtask

  initial begin
    $display("[TB] starting");
    test_reset();
    test_basic();
    test_overrun();
    test_bad_char();
    test_glitch_frame();
    test_reset_mid();
    test_random();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
